// File: rtl/xoodoo_perm_dom_if.sv
// xoodoo_perm_dom_if: start, randomness and result handshakes of the masked Xoodoo engine
interface xoodoo_perm_dom_if;
  logic start, start_ready, rdi_valid, rdi_ready, out_valid, out_ready, busy;
  logic [383:0] in_0, in_1, rdi, out_0, out_1;
  modport master (
    output start, in_0, in_1, rdi, rdi_valid, out_ready,
    input start_ready, rdi_ready, out_0, out_1, out_valid, busy
  );
  modport slave (
    input start, in_0, in_1, rdi, rdi_valid, out_ready,
    output start_ready, rdi_ready, out_0, out_1, out_valid, busy
  );
endinterface

// File: rtl/xoodoo_perm_dom.sv
// xoodoo_perm_dom: iterative two-share DOM-masked Xoodoo, one round per fresh randomness word
module xoodoo_perm_dom #(
  parameter int NUM_ROUNDS = 12
) (
  input logic clk,
  input logic rst,
  xoodoo_perm_dom_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;
  localparam logic [31:0] RC [12] = '{32'h58, 32'h38, 32'h3C0, 32'hD0, 32'h120, 32'h14,
                                      32'h60, 32'h2C, 32'h380, 32'hF0, 32'h1A0, 32'h12};
  state_t state;
  logic [3:0] rcnt, rc_idx;
  logic [383:0] in_r0, in_r1, t00, t01, t10, t11;
  logic [383:0] post0, post1, s0, s1, u0, u1, n00, n01, n10, n11;
  function automatic logic [31:0] rol(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction
  function automatic logic [383:0] theta_rw(input logic [383:0] s);
    logic [31:0] p [4];
    logic [383:0] t, o;
    for (int x = 0; x < 4; x++) p[x] = s[32*x +: 32] ^ s[32*(x+4) +: 32] ^ s[32*(x+8) +: 32];
    for (int i = 0; i < 12; i++) t[32*i +: 32] = s[32*i +: 32] ^ rol(p[(i+3)%4], 5) ^ rol(p[(i+3)%4], 14);
    for (int x = 0; x < 4; x++) begin
      o[32*x +: 32] = t[32*x +: 32];
      o[32*(x+4) +: 32] = t[32*((x+3)%4+4) +: 32];
      o[32*(x+8) +: 32] = rol(t[32*(x+8) +: 32], 11);
    end
    return o;
  endfunction
  function automatic logic [383:0] rho_east(input logic [383:0] s);
    logic [383:0] o;
    for (int x = 0; x < 4; x++) begin
      o[32*x +: 32] = s[32*x +: 32];
      o[32*(x+4) +: 32] = rol(s[32*(x+4) +: 32], 1);
      o[32*(x+8) +: 32] = rol(s[32*((x+2)%4+8) +: 32], 8);
    end
    return o;
  endfunction
  function automatic int ai(input int i);
    return 4*((i/4+1)%3) + i%4;
  endfunction
  function automatic int bi(input int i);
    return 4*((i/4+2)%3) + i%4;
  endfunction
  assign post0 = rho_east(t00 ^ t01);
  assign post1 = rho_east(t10 ^ t11);
  assign s0 = rcnt == 4'd0 ? in_r0 : post0;
  assign s1 = rcnt == 4'd0 ? in_r1 : post1;
  assign rc_idx = 4'(12 - NUM_ROUNDS) + rcnt;
  assign u0 = theta_rw(s0);
  assign u1 = theta_rw(s1) ^ {352'b0, RC[rc_idx]};
  // cross terms are refreshed with the same rdi lane so the two shares recombine to chi
  always_comb begin
    n00 = '0;
    n01 = '0;
    n10 = '0;
    n11 = '0;
    for (int i = 0; i < 12; i++) begin
      n00[32*i +: 32] = (~u0[32*ai(i) +: 32] & u0[32*bi(i) +: 32]) ^ u0[32*i +: 32];
      n01[32*i +: 32] = (~u0[32*ai(i) +: 32] & u1[32*bi(i) +: 32]) ^ bus.rdi[32*i +: 32];
      n10[32*i +: 32] = (u1[32*ai(i) +: 32] & u1[32*bi(i) +: 32]) ^ u1[32*i +: 32];
      n11[32*i +: 32] = (u1[32*ai(i) +: 32] & u0[32*bi(i) +: 32]) ^ bus.rdi[32*i +: 32];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rcnt <= '0;
      in_r0 <= '0;
      in_r1 <= '0;
      t00 <= '0;
      t01 <= '0;
      t10 <= '0;
      t11 <= '0;
    end else if (state == IDLE) begin
      if (bus.start) begin
        in_r0 <= bus.in_0;
        in_r1 <= bus.in_1;
        rcnt <= '0;
        state <= ROUND;
      end
    end else if (state == ROUND) begin
      if (bus.rdi_valid) begin
        t00 <= n00;
        t01 <= n01;
        t10 <= n10;
        t11 <= n11;
        rcnt <= rcnt == 4'(NUM_ROUNDS - 1) ? 4'd0 : rcnt + 4'd1;
        if (rcnt == 4'(NUM_ROUNDS - 1)) state <= DONE;
      end
    end else if (bus.out_ready) begin
      state <= IDLE;
    end
  end
  assign bus.start_ready = state == IDLE;
  assign bus.busy = state != IDLE;
  assign bus.rdi_ready = state == ROUND;
  assign bus.out_valid = state == DONE;
  assign bus.out_0 = bus.out_valid ? post0 : '0;
  assign bus.out_1 = bus.out_valid ? post1 : '0;
endmodule

// File: tb/tb_xoodoo_perm_dom.sv
// tb_xoodoo_perm_dom: scoreboarded bench for 12- and 6-round engines against a plain Xoodoo model
module tb_xoodoo_perm_dom;
  logic clk = 0, rst = 1, start = 0, sel = 0, rdi_valid = 0, out_ready = 0;
  logic [383:0] in0 = '0, in1 = '0, rdi = '0;
  logic ov, sr, rr, bz;
  logic [383:0] obs0, obs1;
  int checks = 0, errors = 0;
  logic [383:0] sb [$];
  xoodoo_perm_dom_if ifa();
  xoodoo_perm_dom_if ifb();
  assign ifa.start = start & ~sel;
  assign ifb.start = start & sel;
  assign ifa.in_0 = in0;
  assign ifb.in_0 = in0;
  assign ifa.in_1 = in1;
  assign ifb.in_1 = in1;
  assign ifa.rdi = rdi;
  assign ifb.rdi = rdi;
  assign ifa.rdi_valid = rdi_valid;
  assign ifb.rdi_valid = rdi_valid;
  assign ifa.out_ready = out_ready;
  assign ifb.out_ready = out_ready;
  xoodoo_perm_dom #(.NUM_ROUNDS(12)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  xoodoo_perm_dom #(.NUM_ROUNDS(6)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
  assign ov = sel ? ifb.out_valid : ifa.out_valid;
  assign sr = sel ? ifb.start_ready : ifa.start_ready;
  assign rr = sel ? ifb.rdi_ready : ifa.rdi_ready;
  assign bz = sel ? ifb.busy : ifa.busy;
  assign obs0 = sel ? ifb.out_0 : ifa.out_0;
  assign obs1 = sel ? ifb.out_1 : ifa.out_1;
  always #5 clk = ~clk;
  function automatic logic [31:0] rl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction
  function automatic logic [383:0] rnd384();
    logic [383:0] v;
    for (int i = 0; i < 12; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction
  function automatic logic [383:0] xoodoo_ref(input logic [383:0] s, input int nr);
    logic [31:0] a [3][4];
    logic [31:0] b [3][4];
    logic [31:0] p [4];
    logic [31:0] e [4];
    logic [31:0] t [4];
    logic [31:0] rc [12];
    logic [383:0] o;
    rc = '{32'h58, 32'h38, 32'h3C0, 32'hD0, 32'h120, 32'h14,
           32'h60, 32'h2C, 32'h380, 32'hF0, 32'h1A0, 32'h12};
    for (int y = 0; y < 3; y++) for (int x = 0; x < 4; x++) a[y][x] = s[32*(4*y+x) +: 32];
    for (int r = 12 - nr; r < 12; r++) begin
      for (int x = 0; x < 4; x++) p[x] = a[0][x] ^ a[1][x] ^ a[2][x];
      for (int x = 0; x < 4; x++) e[x] = rl(p[(x+3)%4], 5) ^ rl(p[(x+3)%4], 14);
      for (int y = 0; y < 3; y++) for (int x = 0; x < 4; x++) a[y][x] ^= e[x];
      for (int x = 0; x < 4; x++) t[x] = a[1][x];
      for (int x = 0; x < 4; x++) begin
        a[1][x] = t[(x+3)%4];
        a[2][x] = rl(a[2][x], 11);
      end
      a[0][0] ^= rc[r];
      for (int y = 0; y < 3; y++) for (int x = 0; x < 4; x++)
        b[y][x] = a[y][x] ^ (~a[(y+1)%3][x] & a[(y+2)%3][x]);
      for (int x = 0; x < 4; x++) begin
        a[0][x] = b[0][x];
        a[1][x] = rl(b[1][x], 1);
        a[2][x] = rl(b[2][(x+2)%4], 8);
      end
    end
    for (int y = 0; y < 3; y++) for (int x = 0; x < 4; x++) o[32*(4*y+x) +: 32] = a[y][x];
    return o;
  endfunction
  task automatic chk(input string tag, input logic [383:0] got, input logic [383:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic call(input logic s, input logic [383:0] x0, input logic [383:0] x1,
                      input int stall_at, input int stall_len, input logic poke,
                      output logic [383:0] res);
    int nr, cyc, hs, st;
    logic [383:0] exp;
    nr = s ? 6 : 12;
    sel = s;
    in0 = x0;
    in1 = x1;
    start = 1;
    sb.push_back(xoodoo_ref(x0 ^ x1, nr));
    @(posedge clk);
    #1;
    start = 0;
    in0 = rnd384();
    in1 = rnd384();
    cyc = 1;
    hs = 0;
    st = 0;
    while (!ov && cyc < 100) begin
      if (hs == stall_at && st < stall_len) begin
        rdi_valid = 0;
        st++;
      end else rdi_valid = 1;
      rdi = rnd384();
      start = poke;
      if (rdi_valid && rr) hs++;
      @(posedge clk);
      #1;
      cyc++;
    end
    start = 0;
    rdi_valid = 0;
    chk("latency", 384'(cyc), 384'(nr + 1 + stall_len));
    chk("rdi_handshakes", 384'(hs), 384'(nr));
    exp = sb.size() != 0 ? sb.pop_front() : '0;
    chk("unmasked_result", obs0 ^ obs1, exp);
    res = obs0;
  endtask
  task automatic release_out();
    out_ready = 1;
    @(posedge clk);
    #1;
    out_ready = 0;
    chk("idle_valid", 384'(ov), 384'(0));
    chk("idle_ready", 384'(sr), 384'(1));
    chk("idle_out0", obs0, '0);
    chk("idle_out1", obs1, '0);
  endtask
  initial begin
    logic [383:0] r, x, o_a, o_b;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    chk("rst_start_ready", 384'(sr), 384'(1));
    chk("rst_busy", 384'(bz), 384'(0));
    chk("rst_rdi_ready", 384'(rr), 384'(0));
    chk("rst_out_valid", 384'(ov), 384'(0));
    chk("rst_out0", obs0, '0);
    chk("rst_out1", obs1, '0);
    r = rnd384();
    call(0, r, r, -1, 0, 0, o_a);
    chk("zero_state_12", obs0 ^ obs1, xoodoo_ref('0, 12));
    release_out();
    for (int j = 0; j < 48; j++) x[8*j +: 8] = 8'(j);
    call(1, '0, x, -1, 0, 0, o_a);
    release_out();
    r = rnd384();
    call(0, r, r, 4, 3, 0, o_a);
    release_out();
    r = rnd384();
    x = rnd384();
    call(0, r, r ^ x, -1, 0, 1, o_a);
    o_b = obs1;
    start = 1;
    in0 = rnd384();
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("hold_valid", 384'(ov), 384'(1));
      chk("hold_out0", obs0, o_a);
      chk("hold_out1", obs1, o_b);
    end
    start = 0;
    release_out();
    sel = 0;
    in0 = r;
    in1 = r ^ x;
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
    rdi_valid = 1;
    repeat (6) begin
      rdi = rnd384();
      @(posedge clk);
      #1;
    end
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    rdi_valid = 0;
    chk("midrst_busy", 384'(bz), 384'(0));
    chk("midrst_ready", 384'(sr), 384'(1));
    chk("midrst_valid", 384'(ov), 384'(0));
    chk("midrst_out0", obs0, '0);
    chk("midrst_out1", obs1, '0);
    call(0, r, r ^ x, -1, 0, 0, o_a);
    release_out();
    x = rnd384();
    r = rnd384();
    call(0, r, r ^ x, -1, 0, 0, o_a);
    release_out();
    r = rnd384();
    call(0, r, r ^ x, -1, 0, 0, o_b);
    release_out();
    chk("share_split_differs", 384'(o_a != o_b), 384'(1));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
